lu_sweep_sequencer: RTL and testbench
=====================================

// Module: lu_sweep_sequencer
// PURPOSE
//  Upstream driver for the 2-input, 8-operation logic unit (sel 000..111 = NOT A, NOT B, AND, NAND,
//  XOR, XNOR, OR, NOR). On start, sweeps the selected operand pairs and all 8 ops.
//  Drives lu_a/lu_b/lu_sel and samples lu_out after a settle window.
//  Packs the sampled bits into a 32-bit truth table for self-check and display logic.
// PARAMETERS
//  SETTLE  1  cycles between driving a combo and sampling lu_out; legal range 1..15
// PORTS
//  clk        in   1   single clock, all state on posedge
//  reset      in   1   synchronous, active-high reset
//  start      in   1   begin sweep; sampled only in IDLE
//  abort      in   1   stop sweep immediately; no done pulse
//  pair_mask  in   4   bit p enables operand pair p = {a,b} (p[1]=a, p[0]=b); captured at start
//  lu_a       out  1   operand A to logic unit (registered)
//  lu_b       out  1   operand B to logic unit (registered)
//  lu_sel     out  3   operation select to logic unit (registered)
//  lu_out     in   1   logic unit result (combinational from lu_a/lu_b/lu_sel)
//  busy       out  1   high while sweeping
//  done       out  1   one-cycle pulse when sweep completes
//  table      out  32  table[p*8+sel] = lu_out sampled for pair p, op sel
// BEHAVIOUR
//  - Reset: state IDLE; lu_a=0, lu_b=0, lu_sel=0; busy=0; done=0; table=0; internal counters=0.
//    Reset overrides everything, including mid-sweep.
//  - FSM states: IDLE, FIND, DRIVE, DONE.
//  - IDLE -> FIND on start=1.
//    - On that edge: capture pair_mask; clear table; busy=1.
//  - FIND: advance the pair index to the lowest enabled pair >= current index.
//    - Zero-cycle lookahead: the next combo is driven on the same edge that leaves the previous one.
//    - No enabled pair remains -> DONE.
//  - Each combo (p, sel): lu_a=p[1], lu_b=p[0], lu_sel=sel, driven from cycle k.
//    - lu_out sampled into table[p*8+sel] on the edge ending cycle k+SETTLE-1.
//    - Next combo driven from cycle k+SETTLE. Each combo costs exactly SETTLE cycles.
//  - Ordering: sel 0..7 inner, pair 0..3 outer. Masked pairs are skipped with no cycles spent.
//    Their table bits stay 0.
//  - First combo is driven in the cycle after the start edge (cycle 1).
//  - DONE: entered on the edge of the last sample.
//    - done=1 and busy=0 for exactly that one cycle; then IDLE.
//    - lu_* return to 0; table holds its value until the next start.
//  - pair_mask=0: done pulses in cycle 1; table=0.
//  - start while busy or in DONE is ignored; pair_mask changes mid-sweep are ignored.
//  - abort=1 while busy: next edge -> IDLE; busy=0; done stays 0; lu_* = 0.
//    Table keeps the bits sampled so far. abort and start together in IDLE: abort wins, no sweep.
//  - Counter widths: sel 3 bits wraps 7->0 with pair increment; pair 2 bits, no wrap.
//    The sweep ends after pair 3 or after the last enabled pair.
//  - done and busy are never high together.
// TESTING (bench instantiates the 8-op logic unit as the lu_out source)
//  1. SETTLE=1, mask=4'hF, start pulse -> busy 32 cycles; done in cycle 33; table=32'h645A59AB.
//  2. SETTLE=1, mask=4'b0010 -> table=32'h00005900; done in cycle 9;
//     lu_a=0, lu_b=1 throughout; lu_sel 0..7.
//  3. mask=4'b0000 -> done in cycle 1; busy never high; table=0.
//  4. SETTLE=3, mask=4'b1000 -> each lu_sel held 3 cycles; table=32'h64000000; done in cycle 25.
//  5. Sweep mask=4'hF:
//     - abort in cycle 10 -> no done; busy low next cycle; table bits above the last sampled index = 0.
//     - Repeat with reset in place of abort -> every output 0.
//  6. start re-pulsed in cycle 5 of a sweep and mask toggled -> identical result to scenario 1.

Source files
------------

// File: rtl/lu_sweep_sequencer.sv
// Sweeps enabled operand pairs and all 8 logic-unit ops, sampling lu_out after a settle window
// and packing results into a 32-bit truth table indexed by {pair, sel}.
module lu_sweep_sequencer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  pair_mask,
    output logic        lu_a,
    output logic        lu_b,
    output logic [2:0]  lu_sel,
    input  logic        lu_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] truth_table,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIND  = 2'd1,
        DRIVE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] mask_q;
    logic [1:0] pair;
    logic [2:0] sel;
    logic [3:0] settle_cnt;
    logic [2:0] first_pair;
    logic [2:0] next_pair;

    // Returns {found, index} of the lowest enabled pair at or above 'from'.
    function automatic logic [2:0] find_pair(input logic [3:0] m, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    // FIND is resolved combinationally so the next combo is driven on the leaving edge.
    always_comb begin
        first_pair = find_pair(pair_mask, 3'd0);
        next_pair  = find_pair(mask_q, {1'b0, pair} + 3'd1);
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mask_q      <= 4'd0;
            pair        <= 2'd0;
            sel         <= 3'd0;
            settle_cnt  <= 4'd0;
            lu_a        <= 1'b0;
            lu_b        <= 1'b0;
            lu_sel      <= 3'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        mask_q      <= pair_mask;
                        truth_table <= 32'd0;
                        settle_cnt  <= 4'd0;
                        sel         <= 3'd0;
                        if (first_pair[2]) begin
                            pair   <= first_pair[1:0];
                            lu_a   <= first_pair[1];
                            lu_b   <= first_pair[0];
                            lu_sel <= 3'd0;
                            busy   <= 1'b1;
                            state  <= DRIVE;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        busy   <= 1'b0;
                        lu_a   <= 1'b0;
                        lu_b   <= 1'b0;
                        lu_sel <= 3'd0;
                        state  <= IDLE;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        truth_table[{pair, sel}] <= lu_out;
                        settle_cnt <= 4'd0;
                        if (sel != 3'd7) begin
                            sel    <= sel + 3'd1;
                            lu_sel <= sel + 3'd1;
                        end else if (next_pair[2]) begin
                            pair   <= next_pair[1:0];
                            sel    <= 3'd0;
                            lu_a   <= next_pair[1];
                            lu_b   <= next_pair[0];
                            lu_sel <= 3'd0;
                        end else begin
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            lu_a   <= 1'b0;
                            lu_b   <= 1'b0;
                            lu_sel <= 3'd0;
                            state  <= DONE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lu_sweep_sequencer.sv
// Bench for lu_sweep_sequencer: directed sweeps against hand-computed truth tables, with a
// scoreboard monitor checking every driven combo and each done pulse.
module tb_lu_sweep_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       abort = 1'b0;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    logic [3:0] mask = 4'd0;
    logic       use3 = 1'b0;

    logic        a1, b1, o1, busy1, done1;
    logic [2:0]  sel1;
    logic [31:0] tab1;
    logic [1:0]  st1;
    logic        a3, b3, o3, busy3, done3;
    logic [2:0]  sel3;
    logic [31:0] tab3;
    logic [1:0]  st3;

    function automatic logic lu_model(input logic a, input logic b, input logic [2:0] s);
        case (s)
            3'd0: return ~a;
            3'd1: return ~b;
            3'd2: return a & b;
            3'd3: return ~(a & b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return a | b;
            default: return ~(a | b);
        endcase
    endfunction

    assign o1 = lu_model(a1, b1, sel1);
    assign o3 = lu_model(a3, b3, sel3);

    lu_sweep_sequencer #(.SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort), .pair_mask(mask),
        .lu_a(a1), .lu_b(b1), .lu_sel(sel1), .lu_out(o1), .busy(busy1), .done(done1),
        .truth_table(tab1), .dbg_state(st1)
    );

    lu_sweep_sequencer #(.SETTLE(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .abort(abort), .pair_mask(mask),
        .lu_a(a3), .lu_b(b3), .lu_sel(sel3), .lu_out(o3), .busy(busy3), .done(done3),
        .truth_table(tab3), .dbg_state(st3)
    );

    logic        m_a, m_b, m_busy, m_done;
    logic [2:0]  m_sel;
    logic [31:0] m_tab;
    logic [1:0]  m_st;
    always_comb begin
        m_a    = use3 ? a3 : a1;
        m_b    = use3 ? b3 : b1;
        m_sel  = use3 ? sel3 : sel1;
        m_busy = use3 ? busy3 : busy1;
        m_done = use3 ? done3 : done1;
        m_tab  = use3 ? tab3 : tab1;
        m_st   = use3 ? st3 : st1;
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [4:0]  combo_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    // Monitor: pops one combo per busy cycle and one table/cycle pair per done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_busy && m_done) check("busy_and_done", 32'd1, 32'd0);
            if (m_busy) begin
                if (combo_q.size() == 0) begin
                    check("unexpected_busy", {31'd0, m_busy}, 32'd0);
                end else begin
                    logic [4:0] c;
                    c = combo_q.pop_front();
                    check("combo", {27'd0, m_a, m_b, m_sel}, {27'd0, c});
                end
            end
            if (m_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {31'd0, m_done}, 32'd0);
                end else begin
                    logic [31:0] et;
                    int ec;
                    et = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("table", m_tab, et);
                    check("done_cycle", 32'(cyc - t0), 32'(ec));
                end
            end
        end
    end

    task automatic push_combos(input logic [3:0] m, input int settle, input int lim);
        int n;
        logic [1:0] pp;
        n = 0;
        for (int p = 0; p < 4; p++) begin
            if (m[p]) begin
                pp = 2'(p);
                for (int s = 0; s < 8; s++) begin
                    for (int k = 0; k < settle; k++) begin
                        if (n < lim) combo_q.push_back({pp, 3'(s)});
                        n++;
                    end
                end
            end
        end
    endtask

    task automatic start_sweep(input logic [3:0] m);
        @(posedge clk); #1;
        mask = m;
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, {31'd0, m_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, m_done}, 32'd0);
        check({tag, "_lu"}, {27'd0, m_a, m_b, m_sel}, 32'd0);
    endtask

    task automatic wait_drained(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && combo_q.size() == 0) break;
            @(posedge clk);
        end
        if (i == budget) begin
            check("timeout_drain", 32'd1, 32'd0);
            exp_q.delete();
            exp_cyc_q.delete();
            combo_q.delete();
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("post_idle");
    endtask

    task automatic run_sweep(input logic [3:0] m, input int settle, input logic [31:0] et, input int ec);
        push_combos(m, settle, 1000);
        exp_q.push_back(et);
        exp_cyc_q.push_back(ec);
        start_sweep(m);
        wait_drained(200);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_table1", tab1, 32'd0);
        check("rst_state1", {30'd0, st1}, 32'd0);
        check_idle("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: full sweep
        run_sweep(4'hF, 1, 32'h645A59AB, 33);
        // 2: single pair 1
        run_sweep(4'b0010, 1, 32'h00005900, 9);
        // 3: empty mask
        run_sweep(4'b0000, 1, 32'h00000000, 1);
        // 4: SETTLE=3, pair 3 only
        use3 = 1'b1;
        run_sweep(4'b1000, 3, 32'h64000000, 25);
        use3 = 1'b0;

        // 5a: abort in cycle 10 keeps samples 0..8
        push_combos(4'hF, 1, 10);
        start_sweep(4'hF);
        repeat (9) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check_idle("abort");
        check("abort_table", tab1, 32'h000001AB);
        check("abort_combos_left", 32'(combo_q.size()), 32'd0);
        repeat (3) @(posedge clk);

        // 5b: reset in cycle 10 clears everything
        push_combos(4'hF, 1, 9);
        start_sweep(4'hF);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset");
        check("reset_table", tab1, 32'd0);
        check("reset_state", {30'd0, st1}, 32'd0);
        combo_q.delete();
        repeat (3) @(posedge clk);

        // abort together with start in IDLE: no sweep
        @(posedge clk); #1;
        start1 = 1'b1;
        abort = 1'b1;
        mask = 4'hF;
        @(posedge clk); #1;
        start1 = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check_idle("abort_start");
        repeat (2) @(posedge clk);

        // 6: restart pulse and mask change mid-sweep are ignored
        push_combos(4'hF, 1, 1000);
        exp_q.push_back(32'h645A59AB);
        exp_cyc_q.push_back(33);
        start_sweep(4'hF);
        repeat (4) @(posedge clk);
        #1 start1 = 1'b1;
        mask = 4'b0001;
        @(posedge clk); #1;
        start1 = 1'b0;
        wait_drained(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
